plab4_net_router_adaptive_input_queue: RTL
==========================================

# plab4_net_router_adaptive_input_queue

Per-port input buffer for the adaptive ring router, directly upstream of the adaptive input terminal control. Buffers incoming network messages, presents the head message and its extracted destination field to the control stage, and exports the current free-entry count. The router routes on that count with the bubble rule: inject only when at least two entries are free.

## Interface
- p_msg_nbits, 44, width of one network message.
- p_dest_lsb, 38, bit index of the destination field LSB within the message.
- p_dest_nbits, 3, destination field width.
- p_num_entries, 2, queue depth, at least 1, any integer (not restricted to powers of two).
- p_num_free_nbits, 2, width of num_free; must hold p_num_entries.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- enq_val  input  1  upstream message valid.
- enq_rdy  output  1  queue can accept a message.
- enq_msg  input  p_msg_nbits  upstream message.
- deq_val  output  1  head entry valid.
- deq_rdy  input  1  downstream accepts head.
- deq_msg  output  p_msg_nbits  head message.
- dest  output  p_dest_nbits  equals deq_msg[p_dest_lsb +: p_dest_nbits].
- num_free  output  p_num_free_nbits  p_num_entries minus current occupancy.

## Operation
- Storage is a circular buffer of p_num_entries registers, with an enqueue pointer, a dequeue pointer and an occupancy count.
- Each pointer increments by one on its transfer. When the pointer equals p_num_entries−1, it returns to 0 (explicit compare, not a power-of-two mask).
- An enqueue transfer occurs when enq_val && enq_rdy. enq_msg is written at the enqueue pointer.
- A dequeue transfer occurs when deq_val && deq_rdy.
- Occupancy update:
  - +1 on enqueue only.
  - −1 on dequeue only.
  - Unchanged when both or neither occur.
- enq_rdy = (count != p_num_entries). This is a normal queue: no pipelined enqueue into a full queue, even if a dequeue happens that cycle.
- deq_val = (count != 0). There is no bypass: a message enqueued in cycle N is visible no earlier than cycle N+1.
- deq_msg is read combinationally from the entry at the dequeue pointer.
- deq_msg and dest are don't-care when deq_val = 0. The bench must not check them then.
- num_free = p_num_entries − count. It is a pure function of registered count, so it never depends combinationally on enq_val or deq_rdy.
- When one entry remains, a simultaneous enqueue and dequeue is legal. The count stays the same and both pointers advance.
- Reset: asserting reset (low) immediately, without a clock, forces count, enq_ptr and deq_ptr to 0. Storage contents are not reset.
- Reset asserted mid-operation discards all buffered messages.

## Timing
- Reset values of outputs:
  - deq_val = 0.
  - enq_rdy = 1.
  - num_free = p_num_entries.
  - deq_msg and dest undefined.
- Latency from enqueue to first possible dequeue: 1 cycle.
- Throughput: one message per cycle sustained while 0 < count < p_num_entries.
- enq_rdy, deq_val and num_free change only after a clock edge or on reset assertion.
- enq_rdy must not depend combinationally on enq_val or deq_rdy.
- deq_val must not depend combinationally on enq_val or deq_rdy.
- Reset deassertion must be seen before a rising edge for state to update on that edge. The first transfer can occur at the first rising edge after deassertion.
- Order is FIFO; no message is reordered, duplicated or dropped.

## Test plan
- Reset: hold reset low with no clock edge.
  - Required: deq_val = 0, enq_rdy = 1, num_free = 2.
  - Then assert reset low mid-run with 2 entries held. Required: same values immediately, before the next edge.
- Single message: enqueue msg with dest = 3'h5 at cycle 1, deq_rdy = 0.
  - Cycle 2 required: deq_val = 1, dest = 5, num_free = 1.
  - Set deq_rdy = 1. Cycle 3 required: deq_val = 0, num_free = 2.
- Fill: enqueue dest 1 then dest 7 with deq_rdy = 0.
  - Required: num_free 2→1→0 and enq_rdy = 0 once full.
  - Further enq_val is ignored. Draining then yields dest 1 then dest 7.
- Full plus simultaneous dequeue: with count = 2, drive enq_val = 1 and deq_rdy = 1.
  - Required: enq_rdy = 0, only the dequeue occurs, num_free = 1 next cycle.
- Streaming with wrap-around: p_num_entries = 3, enq_val and deq_rdy held high for 10 messages with dest 0..7,0,1.
  - Required: output in order, one per cycle after 1 cycle of latency.
  - Required: num_free steady at 2; both pointers wrap 2→0 correctly.
- Random: random enq_val/deq_rdy for 1000 cycles against a scoreboard.
  - Required: FIFO order preserved.
  - Required: num_free always equals p_num_entries minus scoreboard occupancy.

Source files
------------

// File: rtl/plab4_net_router_adaptive_input_queue.sv
// rtl/plab4_net_router_adaptive_input_queue.sv - per-port input buffer for the adaptive ring router
module plab4_net_router_adaptive_input_queue #(
    parameter int p_msg_nbits      = 44,
    parameter int p_dest_lsb       = 38,
    parameter int p_dest_nbits     = 3,
    parameter int p_num_entries    = 2,
    parameter int p_num_free_nbits = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enq_val,
    output logic                        enq_rdy,
    input  logic [p_msg_nbits-1:0]      enq_msg,
    output logic                        deq_val,
    input  logic                        deq_rdy,
    output logic [p_msg_nbits-1:0]      deq_msg,
    output logic [p_dest_nbits-1:0]     dest,
    output logic [p_num_free_nbits-1:0] num_free
);

    localparam int p_ptr_nbits = (p_num_entries > 1) ? $clog2(p_num_entries) : 1;
    localparam int p_cnt_nbits = $clog2(p_num_entries + 1);

    localparam logic [p_ptr_nbits-1:0]      c_last_ptr = p_ptr_nbits'(p_num_entries - 1);
    localparam logic [p_cnt_nbits-1:0]      c_full     = p_cnt_nbits'(p_num_entries);
    localparam logic [p_num_free_nbits-1:0] c_total    = p_num_free_nbits'(p_num_entries);

    logic [p_msg_nbits-1:0] mem [p_num_entries];
    logic [p_ptr_nbits-1:0] enq_ptr;
    logic [p_ptr_nbits-1:0] deq_ptr;
    logic [p_cnt_nbits-1:0] count;

    logic do_enq;
    logic do_deq;

    // Ready/valid come only from registered count, so neither sees enq_val or deq_rdy.
    assign enq_rdy  = (count != c_full);
    assign deq_val  = (count != '0);
    assign do_enq   = enq_val && enq_rdy;
    assign do_deq   = deq_val && deq_rdy;
    assign deq_msg  = mem[deq_ptr];
    assign dest     = deq_msg[p_dest_lsb +: p_dest_nbits];
    assign num_free = c_total - p_num_free_nbits'(count);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            enq_ptr <= '0;
            deq_ptr <= '0;
            count   <= '0;
        end else begin
            if (do_enq) begin
                enq_ptr <= (enq_ptr == c_last_ptr) ? '0 : enq_ptr + 1'b1;
            end
            if (do_deq) begin
                deq_ptr <= (deq_ptr == c_last_ptr) ? '0 : deq_ptr + 1'b1;
            end
            if (do_enq && !do_deq) begin
                count <= count + 1'b1;
            end else if (do_deq && !do_enq) begin
                count <= count - 1'b1;
            end
        end
    end

    // Storage is deliberately left out of reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_enq) begin
            mem[enq_ptr] <= enq_msg;
        end
    end

endmodule
